iic_txn_ctrl: RTL and testbench

IIC_TXN_CTRL -- requirements
Module: iic_txn_ctrl

---
 rtl/iic_pkg.sv | 55 +++++
 rtl/iic_timeout.sv | 30 +++
 rtl/iic_txn_ctrl.sv | 150 +++++++++++++++
 tb/tb_iic_txn_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC transaction controller: FSM states, step
// actions and the R/W bit appended to the 7-bit device address.
package iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_STOP_ISSUE,
        ST_STOP_HI,
        ST_STOP_LO,
        ST_FINISH
    } state_t;

    typedef enum logic [2:0] {
        ACT_ADDR_W,
        ACT_REG,
        ACT_DATA,
        ACT_ADDR_R,
        ACT_RECV,
        ACT_STOP,
        ACT_END
    } act_t;

    localparam logic       ADDR_BIT_W = 1'b0;
    localparam logic       ADDR_BIT_R = 1'b1;
    localparam logic [2:0] STEP_FIRST = 3'd0;

    // Maps the step index of a write or read transaction to the action it performs.
    function automatic act_t step_action(input logic rw, input logic [2:0] step);
        act_t act;
        if (!rw) begin
            case (step)
                3'd0:    act = ACT_ADDR_W;
                3'd1:    act = ACT_REG;
                3'd2:    act = ACT_DATA;
                3'd3:    act = ACT_STOP;
                default: act = ACT_END;
            endcase
        end else begin
            case (step)
                3'd0:    act = ACT_ADDR_W;
                3'd1:    act = ACT_REG;
                3'd2:    act = ACT_STOP;
                3'd3:    act = ACT_ADDR_R;
                3'd4:    act = ACT_RECV;
                3'd5:    act = ACT_STOP;
                default: act = ACT_END;
            endcase
        end
        return act;
    endfunction

endpackage

// File: rtl/iic_timeout.sv
// Per-wait cycle counter: cleared on entry to a wait, counts while enabled,
// and flags expiry once TIMEOUT cycles have been spent waiting.
module iic_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/iic_txn_ctrl.sv
// Register-level IIC transaction sequencer: turns one host write/read request
// into a series of byte-transfer and stop commands for iic_core.
module iic_txn_ctrl
    import iic_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       core_start,
    output logic       core_stop,
    output logic       core_rw,
    output logic [7:0] core_din,
    input  logic       core_busy,
    input  logic [7:0] core_dout
);

    state_t     state;
    logic [2:0] step;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       in_hi;
    logic       in_wait;
    logic       to_clear;
    logic       to_expired;
    act_t       next_act;

    assign in_hi    = (state == ST_WAIT_HI) || (state == ST_STOP_HI);
    assign in_wait  = in_hi || (state == ST_WAIT_LO) || (state == ST_STOP_LO);
    // Counter restarts whenever a wait is entered, including the HI->LO hand-off.
    assign to_clear = !in_wait || (in_hi && core_busy);
    assign next_act = step_action(rw_q, step + 3'd1);

    iic_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (to_clear),
        .enable  (in_wait),
        .expired (to_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            step       <= STEP_FIRST;
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            core_start <= 1'b0;
            core_stop  <= 1'b0;
            core_rw    <= 1'b0;
            core_din   <= '0;
        end else begin
            // NOTE: pulse outputs fall back low every cycle, so each assertion below lasts one cycle.
            core_start <= 1'b0;
            core_stop  <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        rw_q       <= rw;
                        dev_q      <= dev_addr;
                        reg_q      <= reg_addr;
                        wdata_q    <= wdata;
                        step       <= STEP_FIRST;
                        ready      <= 1'b0;
                        core_start <= 1'b1;
                        core_rw    <= 1'b0;
                        core_din   <= {dev_addr, ADDR_BIT_W};
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE:      state <= ST_WAIT_HI;
                ST_STOP_ISSUE: state <= ST_STOP_HI;
                ST_WAIT_HI, ST_STOP_HI: begin
                    if (core_busy) begin
                        state <= (state == ST_WAIT_HI) ? ST_WAIT_LO : ST_STOP_LO;
                    end else if (to_expired) begin
                        state     <= ST_FINISH;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        core_stop <= (state == ST_WAIT_HI);
                    end
                end
                ST_WAIT_LO, ST_STOP_LO: begin
                    if (!core_busy) begin
                        if ((state == ST_WAIT_LO) && (step_action(rw_q, step) == ACT_RECV)) begin
                            rdata <= core_dout;
                        end
                        step <= step + 3'd1;
                        case (next_act)
                            ACT_ADDR_W, ACT_REG, ACT_DATA, ACT_ADDR_R: begin
                                core_start <= 1'b1;
                                core_rw    <= 1'b0;
                                state      <= ST_ISSUE;
                                case (next_act)
                                    ACT_ADDR_W: core_din <= {dev_q, ADDR_BIT_W};
                                    ACT_REG:    core_din <= reg_q;
                                    ACT_DATA:   core_din <= wdata_q;
                                    default:    core_din <= {dev_q, ADDR_BIT_R};
                                endcase
                            end
                            ACT_RECV: begin
                                core_start <= 1'b1;
                                core_rw    <= 1'b1;
                                state      <= ST_ISSUE;
                            end
                            ACT_STOP: begin
                                core_stop <= 1'b1;
                                state     <= ST_STOP_ISSUE;
                            end
                            default: begin
                                done  <= 1'b1;
                                err   <= 1'b0;
                                state <= ST_FINISH;
                            end
                        endcase
                    end else if (to_expired) begin
                        state     <= ST_FINISH;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        core_stop <= (state == ST_WAIT_LO);
                    end
                end
                ST_FINISH: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_txn_ctrl.sv
// Scoreboard bench for iic_txn_ctrl: a behavioural iic_core drives core_busy,
// expected protocol events are queued at stimulus time and popped by a monitor.
module tb_iic_txn_ctrl;

    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       core_start;
    logic       core_stop;
    logic       core_rw;
    logic [7:0] core_din;
    logic       core_busy;
    logic [7:0] core_dout;

    always #5 clock = ~clock;

    iic_txn_ctrl #(.TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .rw         (rw),
        .dev_addr   (dev_addr),
        .reg_addr   (reg_addr),
        .wdata      (wdata),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .core_start (core_start),
        .core_stop  (core_stop),
        .core_rw    (core_rw),
        .core_din   (core_din),
        .core_busy  (core_busy),
        .core_dout  (core_dout)
    );

    typedef enum int {EV_START, EV_STOP, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic       rw;
        logic [7:0] din;
        logic       err;
        logic [7:0] rdata;
        int         gap;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_ev_cyc = 0;
    int         n_starts = 0;
    bit         done_prev = 0;
    logic [7:0] model_rdata = 8'h00;

    // Behavioural core settings, chosen per transaction by the stimulus.
    int         lat = 1;
    int         len = 1;
    bit         dead = 0;
    logic [7:0] rx_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_ev(input ev_kind_t k, input logic r, input logic [7:0] d,
                           input logic e, input logic [7:0] rd, input int gp);
        ev_t ev;
        ev.kind = k; ev.rw = r; ev.din = d; ev.err = e; ev.rdata = rd; ev.gap = gp;
        exp_q.push_back(ev);
    endtask

    // Protocol-level reference: the byte/stop sequence a transaction must produce.
    task automatic expect_txn(input logic r, input logic [6:0] dev, input logic [7:0] ra,
                              input logic [7:0] wd, input logic [7:0] rx, input bit timeout,
                              input int first_gap, input int g);
        if (timeout) begin
            push_ev(EV_START, 1'b0, {dev, 1'b0}, 1'b0, 8'h00, first_gap);
            push_ev(EV_STOP, 1'b0, 8'h00, 1'b0, 8'h00, TO + 2);
            push_ev(EV_DONE, 1'b0, 8'h00, 1'b1, model_rdata, 0);
            return;
        end
        push_ev(EV_START, 1'b0, {dev, 1'b0}, 1'b0, 8'h00, first_gap);
        push_ev(EV_START, 1'b0, ra, 1'b0, 8'h00, g);
        if (!r) begin
            push_ev(EV_START, 1'b0, wd, 1'b0, 8'h00, g);
            push_ev(EV_STOP, 1'b0, 8'h00, 1'b0, 8'h00, g);
        end else begin
            push_ev(EV_STOP, 1'b0, 8'h00, 1'b0, 8'h00, g);
            push_ev(EV_START, 1'b0, {dev, 1'b1}, 1'b0, 8'h00, g);
            push_ev(EV_START, 1'b1, 8'h00, 1'b0, 8'h00, g);
            push_ev(EV_STOP, 1'b0, 8'h00, 1'b0, 8'h00, g);
            model_rdata = rx;
        end
        push_ev(EV_DONE, 1'b0, 8'h00, 1'b0, model_rdata, g);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        check("event_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("event_kind", 32'(k), 32'(e.kind));
        if (k == EV_START) begin
            check("core_rw", 32'(core_rw), 32'(e.rw));
            if (!e.rw) check("core_din", 32'(core_din), 32'(e.din));
        end
        if (k == EV_DONE) begin
            check("done_err", 32'(err), 32'(e.err));
            check("done_rdata", 32'(rdata), 32'(e.rdata));
        end
        if (e.gap >= 0) check("event_gap", 32'(cyc - last_ev_cyc), 32'(e.gap));
        last_ev_cyc = cyc;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n !== 1'b1) begin
            done_prev = 0;
        end else begin
            if (core_start || core_stop) check("start_stop_exclusive", 32'(core_start && core_stop), 32'd0);
            if (done_prev) check("ready_after_done", 32'(ready), 32'd1);
            done_prev = done;
            if (core_start) begin
                n_starts++;
                observe(EV_START);
            end
            if (core_stop) observe(EV_STOP);
            if (done) observe(EV_DONE);
        end
    end

    // Behavioural iic_core: busy rises lat cycles after a command, stays high
    // len further cycles, and presents a received byte as it falls.
    initial begin
        int   phase;
        int   cnt;
        logic rxmode;
        phase = 0; cnt = 0; rxmode = 1'b0;
        core_busy = 1'b0;
        core_dout = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n !== 1'b1) begin
                core_busy = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if ((core_start || core_stop) && !dead) begin
                        rxmode = core_start && core_rw;
                        if (lat == 0) begin
                            core_busy = 1'b1; cnt = len; phase = 2;
                        end else begin
                            cnt = lat; phase = 1;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            core_busy = 1'b1; cnt = len; phase = 2;
                        end
                    end
                    default: begin
                        if (cnt == 0) begin
                            core_busy = 1'b0;
                            core_dout = rxmode ? rx_byte : 8'($urandom);
                            phase = 0;
                        end else begin
                            cnt--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic wait_ready(input logic v, input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (ready !== v && k < 3000);
        check(name, 32'(ready), 32'(v));
    endtask

    task automatic scramble_inputs();
        rw = 1'($urandom); dev_addr = 7'($urandom);
        reg_addr = 8'($urandom); wdata = 8'($urandom);
    endtask

    task automatic run_txn(input logic r, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input logic [7:0] rx, input int l,
                           input int n, input bit d, input int g);
        lat = l; len = n; dead = d; rx_byte = rx;
        check("ready_before_req", 32'(ready), 32'd1);
        expect_txn(r, dev, ra, wd, rx, d, -1, g);
        rw = r; dev_addr = dev; reg_addr = ra; wdata = wd; req = 1'b1;
        wait_ready(1'b0, "req_accepted");
        req = 1'b0;
        scramble_inputs();
        wait_ready(1'b1, "txn_complete");
        tick();
    endtask

    task automatic check_reset_values();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_stop", 32'(core_stop), 32'd0);
        check("rst_core_rw", 32'(core_rw), 32'd0);
        check("rst_core_din", 32'(core_din), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        reset_n = 1'b0; req = 1'b0; rw = 1'b0;
        dev_addr = '0; reg_addr = '0; wdata = '0;
        repeat (3) tick();
        check_reset_values();
        reset_n = 1'b1;
        tick();

        // Directed write and read.
        run_txn(1'b0, 7'h50, 8'h10, 8'hAA, 8'h00, 1, 2, 1'b0, -1);
        run_txn(1'b1, 7'h50, 8'h20, 8'h00, 8'h55, 2, 1, 1'b0, -1);

        // Randomized traffic with random core latency and busy length.
        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b0, -1);
        end

        // Zero-latency core: every command completes in three cycles.
        run_txn(1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 8'h00, 0, 1, 1'b0, 3);
        run_txn(1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 8'hC7, 0, 1, 1'b0, 3);

        // Core never goes busy: timeout abort with one stop and no further start.
        run_txn(1'b0, 7'h50, 8'h10, 8'hAA, 8'h00, 1, 1, 1'b1, -1);
        repeat (5) tick();

        // req held high across two back-to-back transactions.
        lat = 1; len = 2; dead = 0; rx_byte = 8'h6B;
        expect_txn(1'b0, 7'h12, 8'h34, 8'h3C, 8'h00, 1'b0, -1, -1);
        rw = 1'b0; dev_addr = 7'h12; reg_addr = 8'h34; wdata = 8'h3C; req = 1'b1;
        wait_ready(1'b0, "held_accept_first");
        rw = 1'b1; dev_addr = 7'h2D; reg_addr = 8'h77; wdata = 8'hC3;
        expect_txn(1'b1, 7'h2D, 8'h77, 8'hC3, 8'h6B, 1'b0, 2, -1);
        wait_ready(1'b1, "held_idle_between");
        wait_ready(1'b0, "held_accept_second");
        req = 1'b0;
        scramble_inputs();
        wait_ready(1'b1, "held_complete_second");
        tick();

        // Reset during the second byte's WAIT_LO: immediate abort, no done.
        lat = 1; len = 8; dead = 0;
        expect_txn(1'b0, 7'h21, 8'h44, 8'h99, 8'h00, 1'b0, -1, -1);
        base = n_starts;
        rw = 1'b0; dev_addr = 7'h21; reg_addr = 8'h44; wdata = 8'h99; req = 1'b1;
        wait_ready(1'b0, "rst_txn_accept");
        req = 1'b0;
        k = 0;
        while (n_starts < base + 2 && k < 200) begin tick(); k++; end
        check("rst_second_byte_started", 32'(n_starts >= base + 2), 32'd1);
        k = 0;
        while (core_busy !== 1'b1 && k < 200) begin tick(); k++; end
        check("rst_core_busy_seen", 32'(core_busy), 32'd1);
        tick();
        reset_n = 1'b0;
        exp_q.delete();
        model_rdata = 8'h00;
        tick();
        check_reset_values();
        reset_n = 1'b1;
        repeat (12) tick();

        // Recovery after the abort.
        run_txn(1'b1, 7'h33, 8'h05, 8'h00, 8'hE1, 1, 1, 1'b0, -1);
        repeat (4) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
